// File: rtl/sha256_compress.sv
// sha256_compress: iterative SHA-256 compression core, one round per clock.
// Takes a 512-bit block and a 256-bit chaining value and returns the updated
// chaining value after 64 rounds. The message schedule is expanded on the fly
// in a 16-word shift window.
// Optional build macro SHA256_ROUND_TAP_EN adds round_idx/tap_a/tap_e debug
// outputs that expose the current round index and working words a and e.
module sha256_compress (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] block,
  input  logic [255:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] digest,
  output logic         busy
`ifdef SHA256_ROUND_TAP_EN
  ,
  output logic [5:0]   round_idx,
  output logic [31:0]  tap_a,
  output logic [31:0]  tap_e
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, y, z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, y, z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  state_t              state_q, state_d;
  logic [5:0]          t_q, t_d;
  logic [255:0]        hin_q, hin_d;
  logic [31:0]         a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q;
  logic [31:0]         a_d, b_d, c_d, d_d, e_d, f_d, g_d, h_d;
  logic [15:0][31:0]   w_q, w_d;
  logic                out_valid_q, out_valid_d;
  logic [255:0]        digest_q, digest_d;

  logic [31:0]         t1, t2, a_new, e_new, w_new;

  // Round datapath, schedule expansion and FSM next-state.
  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    hin_d       = hin_q;
    a_d = a_q; b_d = b_q; c_d = c_q; d_d = d_q;
    e_d = e_q; f_d = f_q; g_d = g_q; h_d = h_q;
    w_d         = w_q;
    out_valid_d = out_valid_q;
    digest_d    = digest_q;

    t1    = h_q + big_sig1(e_q) + ch(e_q, f_q, g_q) + K_ROM[t_q] + w_q[0];
    t2    = big_sig0(a_q) + maj(a_q, b_q, c_q);
    a_new = t1 + t2;
    e_new = d_q + t1;
    w_new = small_sig1(w_q[14]) + w_q[9] + small_sig0(w_q[1]) + w_q[0];

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          hin_d = state_in;
          a_d   = state_in[255:224];
          b_d   = state_in[223:192];
          c_d   = state_in[191:160];
          d_d   = state_in[159:128];
          e_d   = state_in[127:96];
          f_d   = state_in[95:64];
          g_d   = state_in[63:32];
          h_d   = state_in[31:0];
          for (int i = 0; i < 16; i++) w_d[i] = block[511 - 32*i -: 32];
          t_d     = 6'd0;
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        h_d = g_q; g_d = f_q; f_d = e_q; e_d = e_new;
        d_d = c_q; c_d = b_q; b_d = a_q; a_d = a_new;
        for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
        w_d[15] = w_new;
        if (t_q == 6'd63) begin
          // Feed-forward uses the post-round-63 words directly so the digest
          // is ready on the same edge as the last round.
          digest_d = {hin_q[255:224] + a_new, hin_q[223:192] + a_q,
                      hin_q[191:160] + b_q,   hin_q[159:128] + c_q,
                      hin_q[127:96]  + e_new, hin_q[95:64]   + e_q,
                      hin_q[63:32]   + f_q,   hin_q[31:0]    + g_q};
          out_valid_d = 1'b1;
          t_d         = 6'd0;
          state_d     = ST_DONE;
        end else begin
          t_d = t_q + 6'd1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, working registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      t_q         <= 6'd0;
      hin_q       <= '0;
      a_q <= '0; b_q <= '0; c_q <= '0; d_q <= '0;
      e_q <= '0; f_q <= '0; g_q <= '0; h_q <= '0;
      w_q         <= '0;
      out_valid_q <= 1'b0;
      digest_q    <= '0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      hin_q       <= hin_d;
      a_q <= a_d; b_q <= b_d; c_q <= c_d; d_q <= d_d;
      e_q <= e_d; f_q <= f_d; g_q <= g_d; h_q <= h_d;
      w_q         <= w_d;
      out_valid_q <= out_valid_d;
      digest_q    <= digest_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign digest    = digest_q;

`ifdef SHA256_ROUND_TAP_EN
  assign round_idx = (state_q == ST_IDLE) ? 6'd0  : t_q;
  assign tap_a     = (state_q == ST_IDLE) ? 32'd0 : a_q;
  assign tap_e     = (state_q == ST_IDLE) ? 32'd0 : e_q;
`endif

endmodule

// File: tb/tb_sha256_compress.sv
// Self-checking bench for sha256_compress: known vectors, random blocks against
// a plain-arithmetic SHA-256 model, back-pressure, mid-round reset and
// back-to-back issue. Tap outputs are checked when SHA256_ROUND_TAP_EN is set.
module tb_sha256_compress;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [511:0] block = '0;
  logic [255:0] state_in = '0;
  logic         in_ready, out_valid, busy;
  logic [255:0] digest;
`ifdef SHA256_ROUND_TAP_EN
  logic [5:0]   round_idx;
  logic [31:0]  tap_a, tap_e;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [255:0] IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [255:0] DIG_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_EMPTY =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  localparam logic [31:0] KC [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  sha256_compress dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .block     (block),
    .state_in  (state_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .digest    (digest),
    .busy      (busy)
`ifdef SHA256_ROUND_TAP_EN
    ,
    .round_idx (round_idx),
    .tap_a     (tap_a),
    .tap_e     (tap_e)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, failures so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic ref_compress(input logic [511:0] blk, input logic [255:0] st,
                              output logic [255:0] dig, output logic [31:0] a_r0);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] s0, s1, t1, t2, chv, mjv;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
    for (int j = 0; j < 8; j++) v[j] = st[255 - 32*j -: 32];
    a_r0 = '0;
    for (int i = 0; i < 64; i++) begin
      chv = (v[4] & v[5]) ^ (~v[4] & v[6]);
      mjv = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
      t1  = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + chv + KC[i] + w[i];
      t2  = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + mjv;
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
      if (i == 0) a_r0 = v[0];
    end
    dig = '0;
    for (int j = 0; j < 8; j++) dig[255 - 32*j -: 32] = st[255 - 32*j -: 32] + v[j];
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  function automatic logic [255:0] rand_state();
    logic [255:0] s;
    for (int i = 0; i < 8; i++) s[32*i +: 32] = $urandom;
    return s;
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic accept(input logic [511:0] blk, input logic [255:0] st);
    int n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    in_valid = 1'b1; block = blk; state_in = st;
    @(posedge clk); #1;
    in_valid = 1'b0;
    block    = rand_block();
    state_in = rand_state();
  endtask

  task automatic wait_done(input bit jitter, output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      if (jitter) begin
        in_valid = 1'($urandom);
        block    = rand_block();
        state_in = rand_state();
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (digest !== 256'h0) begin n_fail++; $display("FAIL reset_digest got %h want 0", digest); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle in_ready=%b busy=%b want 1/0", in_ready, busy); end
  endtask

  task automatic test_known(input string name, input logic [511:0] blk, input logic [255:0] exp);
    int lat;
    accept(blk, IV);
    n_checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL %s_busy busy=%b in_ready=%b want 1/0", name, busy, in_ready); end
    wait_done(1'b0, lat);
    n_checks++; if (lat !== 64) begin n_fail++; $display("FAIL %s_latency got %0d want 64", name, lat); end
    n_checks++; if (digest !== exp) begin n_fail++; $display("FAIL %s_digest got %h want %h", name, digest, exp); end
    handshake();
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL %s_handshake out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready); end
    n_checks++; if (digest !== exp) begin n_fail++; $display("FAIL %s_digest_hold got %h want %h", name, digest, exp); end
  endtask

  task automatic test_random();
    logic [511:0] blk;
    logic [255:0] st, exp;
    logic [31:0]  a0;
    int lat;
    for (int k = 0; k < 4; k++) begin
      blk = rand_block();
      st  = rand_state();
      ref_compress(blk, st, exp, a0);
      accept(blk, st);
      wait_done(1'b1, lat);
      n_checks++; if (lat !== 64) begin n_fail++; $display("FAIL random%0d_latency got %0d want 64", k, lat); end
      n_checks++; if (digest !== exp) begin n_fail++; $display("FAIL random%0d_digest got %h want %h", k, digest, exp); end
      handshake();
    end
  endtask

  task automatic test_backpressure();
    logic [511:0] blk;
    logic [255:0] st, exp;
    logic [31:0]  a0;
    int lat;
    blk = rand_block();
    st  = rand_state();
    ref_compress(blk, st, exp, a0);
    accept(blk, st);
    wait_done(1'b1, lat);
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      n_checks++; if (digest !== exp) begin n_fail++; $display("FAIL bp_digest cycle %0d got %h want %h", i, digest, exp); end
      n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_flags cycle %0d in_ready=%b out_valid=%b want 0/1", i, in_ready, out_valid); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    handshake();
    n_checks++; if (out_valid !== 1'b0 || digest !== exp) begin n_fail++; $display("FAIL bp_release out_valid=%b digest=%h want 0/%h", out_valid, digest, exp); end
  endtask

  task automatic test_reset_midround();
    bit saw_valid = 1'b0;
    accept(BLK_ABC, IV);
    repeat (30) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_flags in_ready=%b busy=%b out_valid=%b want 1/0/0", in_ready, busy, out_valid); end
    n_checks++; if (digest !== 256'h0) begin n_fail++; $display("FAIL midreset_digest got %h want 0", digest); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if (out_valid) saw_valid = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++; if (saw_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_no_output saw out_valid=%b want 0", saw_valid); end
    test_known("abc_after_reset", BLK_ABC, DIG_ABC);
  endtask

  task automatic test_back_to_back();
    logic [511:0] b1, b2;
    logic [255:0] s1, s2, e1, e2;
    logic [31:0]  a0;
    int acc [4];
    int hs [2];
    logic [255:0] dg [2];
    int nacc = 0, nhs = 0, i = 0;
    bit switch_pending;
    b1 = rand_block(); s1 = rand_state();
    b2 = rand_block(); s2 = rand_state();
    ref_compress(b1, s1, e1, a0);
    ref_compress(b2, s2, e2, a0);
    in_valid = 1'b1; block = b1; state_in = s1; out_ready = 1'b1;
    while (nhs < 2 && i < 300) begin
      switch_pending = 1'b0;
      if (in_valid && in_ready && nacc < 4) begin
        acc[nacc] = i;
        if (nacc == 0) switch_pending = 1'b1;
        nacc++;
      end
      if (out_valid && out_ready) begin
        hs[nhs] = i;
        dg[nhs] = digest;
        nhs++;
      end
      @(posedge clk); #1;
      i++;
      if (switch_pending) begin block = b2; state_in = s2; end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_checks++; if (nhs !== 2 || nacc !== 2) begin n_fail++; $display("FAIL b2b_counts accepts=%0d outputs=%0d want 2/2", nacc, nhs); end
    if (nhs == 2 && nacc >= 2) begin
      n_checks++; if (acc[1] - hs[0] !== 1) begin n_fail++; $display("FAIL b2b_gap accept2-handshake1 got %0d want 1", acc[1] - hs[0]); end
      n_checks++; if (acc[1] - acc[0] !== 66) begin n_fail++; $display("FAIL b2b_interval got %0d want 66", acc[1] - acc[0]); end
      n_checks++; if (dg[0] !== e1) begin n_fail++; $display("FAIL b2b_digest1 got %h want %h", dg[0], e1); end
      n_checks++; if (dg[1] !== e2) begin n_fail++; $display("FAIL b2b_digest2 got %h want %h", dg[1], e2); end
    end
  endtask

`ifdef SHA256_ROUND_TAP_EN
  task automatic test_taps();
    logic [255:0] exp;
    logic [31:0]  a0;
    ref_compress(BLK_ABC, IV, exp, a0);
    n_checks++; if (round_idx !== 6'd0 || tap_a !== 32'd0 || tap_e !== 32'd0) begin n_fail++; $display("FAIL tap_idle idx=%0d a=%h e=%h want 0", round_idx, tap_a, tap_e); end
    accept(BLK_ABC, IV);
    for (int k = 0; k < 64; k++) begin
      n_checks++; if (round_idx !== 6'(k)) begin n_fail++; $display("FAIL tap_round_idx got %0d want %0d", round_idx, k); end
      if (k == 1) begin
        n_checks++; if (tap_a !== a0) begin n_fail++; $display("FAIL tap_a_round0 got %h want %h", tap_a, a0); end
      end
      @(posedge clk); #1;
    end
    n_checks++; if (out_valid !== 1'b1 || digest !== exp) begin n_fail++; $display("FAIL tap_digest out_valid=%b digest=%h want 1/%h", out_valid, digest, exp); end
    handshake();
    n_checks++; if (tap_a !== 32'd0 || round_idx !== 6'd0) begin n_fail++; $display("FAIL tap_back_idle a=%h idx=%0d want 0", tap_a, round_idx); end
  endtask
`endif

  initial begin
    test_reset();
    test_known("abc", BLK_ABC, DIG_ABC);
    test_known("empty", BLK_EMPTY, DIG_EMPTY);
    test_random();
    test_backpressure();
    test_reset_midround();
    test_back_to_back();
`ifdef SHA256_ROUND_TAP_EN
    test_taps();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_compress.md
# sha256_compress

Iterative SHA-256 compression core: accepts one 512-bit message block plus a 256-bit chaining state and produces the updated 256-bit state after 64 rounds, one round per clock. It consumes the combinational Σ0 (rotr 2/13/22), Σ1, Ch, Maj, σ0 and σ1 helpers, and expands the message schedule internally. The mining datapath feeds it from the block/nonce assembler and drains it into the double-hash sequencer.

## Interface
- No parameters; all widths are fixed by SHA-256.
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  block and state_in are valid
- in_ready  out  1  core idle and able to accept; reset value 1
- block  in  512  message block, big-endian; block[511:480] is W0, block[31:0] is W15
- state_in  in  256  chaining value H0..H7; state_in[255:224] is H0
- out_valid  out  1  digest valid; reset value 0
- out_ready  in  1  consumer accepts digest
- digest  out  256  updated state, same packing as state_in; reset value 0
- busy  out  1  high in ROUND or DONE; reset value 0

## Operation
- States: IDLE, ROUND, DONE.
- IDLE: in_ready=1. When in_valid, on that edge capture state_in into an H register, load a..h from state_in, load the 16-word W window from block, set round counter t=0, and go to ROUND.
- ROUND: each edge applies round t using K[t] from an internal 64-entry constant ROM.
  - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + W_t.
  - T2 = Σ0(a) + Maj(a,b,c).
  - Update h←g, g←f, f←e, e←d+T1, d←c, c←b, b←a, a←T1+T2.
- Message schedule uses a 16-word shift window. W_t is always window word 0. Each round shifts the window and appends σ1(W[14]) + W[9] + σ0(W[1]) + W[0].
- All additions are mod 2^32, with carries discarded.
- On the edge that applies round 63: digest ← {H0+a', …, H7+h'}, where a'..h' are the post-round-63 values (per-word mod 2^32). out_valid←1 and the state goes to DONE. t wraps to 0.
- DONE: digest and out_valid stay stable until out_ready=1. On that edge out_valid←0 and the state goes to IDLE; digest keeps its value.
- in_valid is ignored outside IDLE. Changes to block/state_in after acceptance have no effect.
- rst_n low at any time, including mid-round: immediately IDLE, t=0, out_valid=0, digest=0, busy=0, in_ready=1. Working registers are cleared.

## Timing
- Accept edge E0. Rounds 0..63 are applied on edges E1..E64. out_valid rises after E64, giving 64 cycles from accept to out_valid.
- With out_ready held high, out_valid is high for exactly one cycle. The next block can be accepted one cycle after the output handshake, giving a minimum issue interval of 66 cycles.
- in_ready is combinationally equal to (state==IDLE).
- No combinational path runs from out_ready to out_valid or digest.
- Critical path: T1+T2 adder chain. There is no internal pipelining.

## Configuration
- SHA256_ROUND_TAP_EN defined: adds output ports round_idx [5:0] (current t) and tap_a, tap_e [31:0] (current a, e) for mid-round checking against a software model. These outputs are 0 in reset and in IDLE.
- Not defined: those ports do not exist. Functional behaviour and timing are otherwise identical.

## Test plan
- Reset: hold rst_n low, release -> in_ready=1, out_valid=0, busy=0, digest=0.
- "abc" block (0x61626380, zeros, last word 0x00000018) with state_in = IV 6a09e667…5be0cd19 -> after 64 cycles digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Empty-message block (0x80000000 followed by zeros) with IV -> digest = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Back-pressure: out_ready low for 20 cycles after out_valid -> digest stable and in_ready=0 throughout. Also toggle in_valid/block mid-round -> result unchanged.
- Reset pulse at round 30 -> immediate IDLE, out_valid never asserts. A following "abc" run gives the correct digest.
- Two back-to-back blocks with in_valid held high: second accepted exactly one cycle after the first output handshake, and both digests are correct. With SHA256_ROUND_TAP_EN, round_idx steps 0..63 and tap_a after round 0 matches the model.
